// File: rtl/cp0_mem_pkg.sv
// cp0_mem_pkg
//   Shared constants for the MEM-stage coprocessor 0: register indices,
//   SR/Cause field positions, exception codes and the bubble PC.
package cp0_mem_pkg;

  // CP0 register numbers (rd field of mfc0/mtc0)
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LSB = 10;

  // Cause field positions
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD      = 31;

  // Exception codes (bits [6:2] of Cause)
  localparam logic [6:2] EXC_INT  = 5'd0;
  localparam logic [6:2] EXC_ADEL = 5'd4;
  localparam logic [6:2] EXC_ADES = 5'd5;
  localparam logic [6:2] EXC_RI   = 5'd10;
  localparam logic [6:2] EXC_OV   = 5'd12;

  // Word PC carried by a pipeline bubble
  localparam logic [31:2] BUBBLE_PC = 30'hc00;

endpackage

// File: rtl/cp0_mem.sv
// cp0_mem
//   Coprocessor 0 living in the MEM stage. Holds SR, Cause, EPC and PRId,
//   decides every cycle whether the MEM instruction is replaced by an
//   exception/interrupt entry, and serves mfc0/mtc0/eret.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   RA            CP0 register address for mfc0 read and mtc0 write
//   Wdata         mtc0 write data
//   mtc0, eret    MEM-stage instruction flags
//   PC            word PC [31:2] of the MEM instruction
//   ExcCode       exception code carried down the pipe (0 = none)
//   BD            MEM instruction is in a branch delay slot
//   HWInt         level-sensitive hardware interrupt lines
//   Rdata         mfc0 read data (combinational)
//   EPC_out       current EPC, used for eret redirection
//   IntReq        take exception/interrupt this cycle; flushes the pipe
module cp0_mem
  import cp0_mem_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4D495053,
  parameter int          IM_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      RA,
  input  logic [31:0]     Wdata,
  input  logic            mtc0,
  input  logic            eret,
  input  logic [31:2]     PC,
  input  logic [6:2]      ExcCode,
  input  logic            BD,
  input  logic [IM_W-1:0] HWInt,
  output logic [31:0]     Rdata,
  output logic [31:2]     EPC_out,
  output logic            IntReq
);

  // SR fields
  logic [IM_W-1:0] im_q, im_d;
  logic            exl_q, exl_d;
  logic            ie_q, ie_d;
  // Cause fields
  logic            bd_q, bd_d;
  logic [IM_W-1:0] ip_q;
  logic [6:2]      exc_q, exc_d;
  // EPC
  logic [31:2]     epc_q, epc_d;

  logic int_take;
  logic exc_take;

  // Interrupts are judged against the live lines, not the sampled IP,
  // so an enabled line is taken in the same cycle it is seen.
  assign int_take = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_take = (ExcCode != EXC_INT) & ~exl_q;
  assign IntReq   = int_take | exc_take;
  assign EPC_out  = epc_q;

  // Read path: current register contents only, no same-cycle mtc0 bypass.
  always_comb begin
    Rdata = '0;
    case (RA)
      CP0_SR: begin
        Rdata[SR_IM_LSB +: IM_W] = im_q;
        Rdata[SR_EXL]            = exl_q;
        Rdata[SR_IE]             = ie_q;
      end
      CP0_CAUSE: begin
        Rdata[CAUSE_BD]                = bd_q;
        Rdata[CAUSE_IP_LSB +: IM_W]    = ip_q;
        Rdata[CAUSE_EXC_LSB +: 5]      = exc_q;
      end
      CP0_EPC:  Rdata = {epc_q, 2'b00};
      CP0_PRID: Rdata = PRID;
      default:  Rdata = '0;
    endcase
  end

  // Next state: exception/interrupt entry beats mtc0, which beats eret.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (IntReq) begin
      exl_d = 1'b1;
      bd_d  = BD;
      exc_d = int_take ? EXC_INT : ExcCode;
      // Delay-slot instructions restart at the branch; wraps at 30 bits.
      epc_d = BD ? (PC - 30'd1) : PC;
    end else if (mtc0) begin
      if (RA == CP0_SR) begin
        im_d  = Wdata[SR_IM_LSB +: IM_W];
        exl_d = Wdata[SR_EXL];
        ie_d  = Wdata[SR_IE];
      end else if (RA == CP0_EPC) begin
        epc_d = Wdata[31:2];
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= HWInt;  // pending lines are visible to software every cycle
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_mem.sv
module tb_cp0_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RA;
  logic [31:0] Wdata;
  logic        mtc0;
  logic        eret;
  logic [31:2] PC;
  logic [6:2]  ExcCode;
  logic        BD;
  logic [5:0]  HWInt;
  logic [31:0] Rdata;
  logic [31:2] EPC_out;
  logic        IntReq;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_mem dut (
    .clk    (clk),
    .reset  (reset),
    .RA     (RA),
    .Wdata  (Wdata),
    .mtc0   (mtc0),
    .eret   (eret),
    .PC     (PC),
    .ExcCode(ExcCode),
    .BD     (BD),
    .HWInt  (HWInt),
    .Rdata  (Rdata),
    .EPC_out(EPC_out),
    .IntReq (IntReq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) begin
      $display("check %-14s observed %h expected %h", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] ra, input logic [31:0] exp);
    RA = ra;
    #1;
    chk(tag, Rdata, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; RA = '0; Wdata = '0; mtc0 = 1'b0; eret = 1'b0;
    PC = 30'hc00; ExcCode = '0; BD = 1'b0; HWInt = '0;

    // Reset then read
    tick;
    reset = 1'b0;
    rd("rst_sr",    5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc",   5'd14, 32'h0);
    rd("rst_prid",  5'd15, 32'h4D495053);
    rd("rst_other", 5'd3,  32'h0);
    chk("rst_intreq", {31'b0, IntReq}, 32'h0);
    chk("rst_epcout", {2'b00, EPC_out}, 32'h0);

    // Enable IM[10] + IE
    RA = 5'd12; Wdata = 32'h0000_0401; mtc0 = 1'b1;
    tick;
    mtc0 = 1'b0;
    rd("sr_write", 5'd12, 32'h0000_0401);
    chk("no_int_idle", {31'b0, IntReq}, 32'h0);

    // Interrupt on line 0
    HWInt = 6'b000001; PC = 30'h0C05;
    #1;
    chk("int_req", {31'b0, IntReq}, 32'h1);
    tick;
    rd("int_sr",    5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0000_0400);
    chk("int_epc", {2'b00, EPC_out}, 32'h0000_0C05);
    chk("int_masked_exl", {31'b0, IntReq}, 32'h0);
    HWInt = 6'b0;

    // Delay-slot overflow exception with IE=0, EXL cleared
    RA = 5'd12; Wdata = 32'h0000_0400; mtc0 = 1'b1;
    tick;
    mtc0 = 1'b0;
    ExcCode = 5'd12; BD = 1'b1; PC = 30'h0C10;
    #1;
    chk("exc_req", {31'b0, IntReq}, 32'h1);
    tick;
    ExcCode = 5'd0; BD = 1'b0;
    rd("exc_cause", 5'd13, 32'h8000_0030);
    chk("exc_epc", {2'b00, EPC_out}, 32'h0000_0C0F);
    rd("exc_epc_rd", 5'd14, 32'h0000_303C);
    rd("exc_sr", 5'd12, 32'h0000_0402);

    // Nested masking: EXL=1 with IE set
    RA = 5'd12; Wdata = 32'h0000_0403; mtc0 = 1'b1;
    tick;
    mtc0 = 1'b0;
    ExcCode = 5'd4; HWInt = 6'b000001; PC = 30'h0C20;
    #1;
    chk("nest_masked", {31'b0, IntReq}, 32'h0);
    tick;
    ExcCode = 5'd0;
    rd("nest_cause", 5'd13, 32'h8000_0430);
    chk("nest_epc", {2'b00, EPC_out}, 32'h0000_0C0F);
    rd("nest_sr", 5'd12, 32'h0000_0403);
    eret = 1'b1;
    #1;
    chk("eret_cycle", {31'b0, IntReq}, 32'h0);
    tick;
    eret = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("pending_taken", {31'b0, IntReq}, 32'h1);

    // Interrupt entry beats a same-cycle mtc0 to EPC
    RA = 5'd14; Wdata = 32'h1234_5678; mtc0 = 1'b1; PC = 30'h0C30; BD = 1'b0;
    tick;
    mtc0 = 1'b0;
    chk("simul_epc", {2'b00, EPC_out}, 32'h0000_0C30);
    rd("simul_cause", 5'd13, 32'h0000_0400);
    rd("simul_sr", 5'd12, 32'h0000_0403);

    // Cause is read-only
    RA = 5'd13; Wdata = 32'hFFFF_FFFF; mtc0 = 1'b1;
    tick;
    mtc0 = 1'b0;
    rd("ro_cause", 5'd13, 32'h0000_0400);

    // Reset while EXL=1
    reset = 1'b1;
    tick;
    reset = 1'b0;
    rd("mid_rst_sr",    5'd12, 32'h0);
    rd("mid_rst_cause", 5'd13, 32'h0);
    rd("mid_rst_epc",   5'd14, 32'h0);
    chk("mid_rst_int", {31'b0, IntReq}, 32'h0);

    // EPC wrap: delay-slot exception at PC 0
    ExcCode = 5'd4; BD = 1'b1; PC = 30'h0;
    #1;
    chk("wrap_req", {31'b0, IntReq}, 32'h1);
    tick;
    ExcCode = 5'd0; BD = 1'b0;
    chk("wrap_epc", {2'b00, EPC_out}, 32'h3FFF_FFFF);
    rd("wrap_cause", 5'd13, 32'h8000_0410);

    // mtc0 and eret together: mtc0 wins, EXL kept
    RA = 5'd14; Wdata = 32'h0000_0100; mtc0 = 1'b1; eret = 1'b1;
    tick;
    mtc0 = 1'b0; eret = 1'b0;
    rd("both_sr", 5'd12, 32'h0000_0002);
    chk("both_epc", {2'b00, EPC_out}, 32'h0000_0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_mem.md
Name: cp0_mem

Overview:
- Coprocessor-0 for the MEM stage.
- Consumes the exception, eret, mtc0/mfc0 and BD fields registered by the EX/MEM pipeline register, plus the external hardware interrupt lines.
- Holds SR, Cause, EPC and PRId, and decides each cycle whether the instruction in MEM is replaced by an exception or interrupt entry.
- Drives the global flush request, EPC for eret redirection, and mfc0 read data toward the MEM/WB register.

Parameters:
- PRID, 32'h4D495053, value returned when reading register 15.
- IM_W, 6, number of hardware interrupt lines (maps to bits [15:10]).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- RA  in  5  CP0 register address for both mfc0 read and mtc0 write (rd field).
- Wdata  in  32  mtc0 write data.
- mtc0  in  1  write enable from the MEM-stage instruction.
- eret  in  1  eret in MEM.
- PC  in  [31:2]  word PC of the MEM instruction (bubble PC is 30'hc00).
- ExcCode  in  [6:2]  exception code carried down the pipe; 0 means none.
- BD  in  1  MEM instruction sits in a branch delay slot.
- HWInt  in  IM_W  level-sensitive hardware interrupt lines.
- Rdata  out  32  mfc0 read data (combinational).
- EPC_out  out  [31:2]  current EPC.
- IntReq  out  1  take an exception/interrupt this cycle (combinational); flushes IF/ID/EX/MEM.

Behaviour:
- Reset (synchronous, on the clk edge with reset=1): SR=0 (IM=0, EXL=0, IE=0); Cause=0; EPC=0. After reset: IntReq=0, EPC_out=0.
- SR (reg 12): IM[15:10], EXL[1], IE[0]. Other bits read 0.
- Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
- EPC (reg 14): [31:2] stored, [1:0] read 0.
- PRId (reg 15): PRID.
- Any other address reads 0.
- Read path: Rdata = mux(RA) of current register values, with no bypass of a same-cycle mtc0.
- Interrupt: Int = |(HWInt & IM) & IE & !EXL.
- Exception: Exc = (ExcCode != 0) & !EXL.
- IntReq = Int | Exc.
- Priority: interrupt over exception, and both over mtc0 and eret.
- IP is sampled every cycle: Cause.IP <= HWInt, unconditionally unless reset.
- On IntReq at the clk edge:
  - EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= Int ? 0 : ExcCode.
  - EPC <= BD ? PC-1 : PC, with 30-bit wrap allowed.
  - The mtc0 of the same cycle is discarded.
- Else if mtc0:
  - RA=12 writes IM, EXL and IE from Wdata.
  - RA=14 writes EPC from Wdata[31:2].
  - RA=13 and RA=15 are read-only; the write is ignored.
- Else if eret: EXL <= 0. EPC_out is already stable, so upstream redirects combinationally.
- eret together with mtc0 cannot occur: they are different instructions. If both are asserted, mtc0 wins and EXL is untouched unless RA=12.
- A bubble (ExcCode=0, PC=30'hc00) can still take an interrupt. Its EPC=30'hc00 restarts at 0x3000; this is accepted behaviour, documented for software.
- Latency: register updates are visible to Rdata and IntReq on the cycle after the edge.
- An interrupt raised while EXL=1 stays pending in IP. It is taken the cycle after eret or an mtc0 clears EXL.

Decomposition:
- Shared package: CP0 register indices (12/13/14/15), SR and Cause bit positions, exception code constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), and the bubble PC 30'hc00.
- No sub-module; a single module is the natural size (~150 RTL lines).

Test Plan:
- Reset then read: reset=1 for one cycle, then RA=12/13/14/15 -> Rdata = 0, 0, 0, 32'h4D495053; IntReq=0.
- Enable and interrupt:
  - mtc0 RA=12, Wdata=32'h0000_0401 -> SR=32'h401.
  - Next cycle HWInt=6'b000001, PC=30'h0C05 -> IntReq=1 that cycle.
  - After the edge: EXL=1, Cause=32'h0000_0400, EPC_out=30'h0C05.
- Delay-slot exception: SR.IE=0, ExcCode=5'd12, BD=1, PC=30'h0C10 -> IntReq=1; next cycle Cause=32'h8000_0030 (with IP tracking HWInt) and EPC=30'h0C0F.
- Nested masking:
  - With EXL=1, assert ExcCode=4 and HWInt enabled -> IntReq=0, no register change except IP.
  - eret -> EXL=0, and IntReq=1 on the following cycle.
- Simultaneous events: IntReq condition plus mtc0 RA=14 Wdata=32'h1234_5678 in the same cycle -> EPC gets PC, not 32'h1234_5678.
- Read-only and reset mid-operation:
  - mtc0 RA=13 Wdata=32'hFFFF_FFFF -> Cause unchanged.
  - Assert reset while EXL=1 -> SR, Cause and EPC become 0 on that edge.
